// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game-state controller: ball/paddle motion, scoring, serve/play/game-over sequencing
// Updates once per frame_tick; every output comes straight from a register.
module pong_game_ctrl #(
    parameter int BALL_SIZE    = 5,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 120,
    parameter int P1_X         = 20,
    parameter int P2_X         = 610,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_DELAY  = 60
) (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic       P1_up,
    input  logic       P1_down,
    input  logic       P2_up,
    input  logic       P2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] P1_paddle_y,
    output logic [9:0] P2_paddle_y,
    output logic [3:0] P1_score,
    output logic [3:0] P2_score,
    output logic [2:0] state,
    output logic       game_over
);

    localparam int CW = $clog2(SERVE_DELAY + 1);

    localparam logic [10:0] C_TOP        = 11'd2;
    localparam logic [10:0] C_BALL_Y_MAX = 11'(478 - BALL_SIZE);
    localparam logic [10:0] C_PAD_Y_MAX  = 11'(478 - PADDLE_H);
    localparam logic [10:0] C_P1_FACE    = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] C_P2_FACE    = 11'(P2_X - BALL_SIZE);
    localparam logic [10:0] C_BSPD       = 11'(BALL_SPEED);
    localparam logic [10:0] C_PSPD       = 11'(PADDLE_SPEED);
    localparam logic [10:0] C_BSIZE      = 11'(BALL_SIZE);
    localparam logic [10:0] C_PH         = 11'(PADDLE_H);
    localparam logic [10:0] C_RIGHT_WALL = 11'd637;
    localparam logic [9:0]  C_CX         = 10'd320;
    localparam logic [9:0]  C_CY         = 10'd240;
    localparam logic [9:0]  C_PAD0       = 10'd180;
    localparam logic [3:0]  C_WIN        = 4'(WIN_SCORE);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(SERVE_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_POINT      = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    state_t        r_state, w_next_state;
    logic          r_game_over;
    logic [9:0]    r_ball_x, r_ball_y, r_p1_y, r_p2_y;
    logic [9:0]    w_ball_x_nxt, w_ball_y_nxt, w_p1_y_nxt, w_p2_y_nxt;
    logic          r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
    logic [3:0]    r_p1_score, r_p2_score, w_p1_score_nxt, w_p2_score_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_point_p2, w_point_p2_nxt;

    logic [10:0]   w_bx, w_by, w_p1, w_p2;
    logic          w_ov1, w_ov2, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
    logic [3:0]    w_scorer, w_score_inc;
    logic          w_win;

    // Clamped paddle step; compares before subtracting so the row never wraps.
    function automatic logic [9:0] f_paddle(input logic [9:0] py, input logic up, input logic dn);
        logic [10:0] w_py;
        w_py     = {1'b0, py};
        f_paddle = py;
        if (up && !dn)
            f_paddle = (w_py <= C_TOP + C_PSPD) ? 10'(C_TOP) : 10'(w_py - C_PSPD);
        else if (dn && !up)
            f_paddle = (w_py + C_PSPD >= C_PAD_Y_MAX) ? 10'(C_PAD_Y_MAX) : 10'(w_py + C_PSPD);
    endfunction

    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {1'b0, r_ball_y};
    assign w_p1 = {1'b0, r_p1_y};
    assign w_p2 = {1'b0, r_p2_y};

    assign w_ov1    = (w_by + C_BSIZE > w_p1) && (w_by < w_p1 + C_PH);
    assign w_ov2    = (w_by + C_BSIZE > w_p2) && (w_by < w_p2 + C_PH);
    assign w_hit_l  = !r_dir_x && (w_bx >= C_P1_FACE) && (w_bx <= C_P1_FACE + C_BSPD) && w_ov1;
    assign w_miss_l = !r_dir_x && !w_hit_l && (w_bx <= C_TOP + C_BSPD);
    assign w_hit_r  = r_dir_x && (w_bx <= C_P2_FACE) && (w_bx + C_BSPD >= C_P2_FACE) && w_ov2;
    assign w_miss_r = r_dir_x && !w_hit_r && (w_bx + C_BSIZE + C_BSPD >= C_RIGHT_WALL);

    assign w_scorer    = r_point_p2 ? r_p2_score : r_p1_score;
    assign w_score_inc = (w_scorer >= C_WIN) ? C_WIN : w_scorer + 4'd1;
    assign w_win       = (w_score_inc == C_WIN);

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_game_over <= (w_next_state == S_GAME_OVER);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (serve) w_next_state = S_SERVE_WAIT;
            S_SERVE_WAIT: if (frame_tick && r_cnt == C_CNT_LAST) w_next_state = S_PLAY;
            S_PLAY:       if (frame_tick && (w_miss_l || w_miss_r)) w_next_state = S_POINT;
            S_POINT:      w_next_state = w_win ? S_GAME_OVER : S_SERVE_WAIT;
            S_GAME_OVER:  if (serve) w_next_state = S_SERVE_WAIT;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_ball_x_nxt   = r_ball_x;
        w_ball_y_nxt   = r_ball_y;
        w_dir_x_nxt    = r_dir_x;
        w_dir_y_nxt    = r_dir_y;
        w_p1_y_nxt     = r_p1_y;
        w_p2_y_nxt     = r_p2_y;
        w_p1_score_nxt = r_p1_score;
        w_p2_score_nxt = r_p2_score;
        w_cnt_nxt      = r_cnt;
        w_point_p2_nxt = r_point_p2;
        case (r_state)
            S_IDLE: if (serve) w_cnt_nxt = '0;
            S_SERVE_WAIT: if (frame_tick) begin
                w_p1_y_nxt = f_paddle(r_p1_y, P1_up, P1_down);
                w_p2_y_nxt = f_paddle(r_p2_y, P2_up, P2_down);
                w_cnt_nxt  = (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
            S_PLAY: if (frame_tick) begin
                w_p1_y_nxt = f_paddle(r_p1_y, P1_up, P1_down);
                w_p2_y_nxt = f_paddle(r_p2_y, P2_up, P2_down);
                if (r_dir_y) begin
                    if (w_by + C_BSPD >= C_BALL_Y_MAX) begin
                        w_ball_y_nxt = 10'(C_BALL_Y_MAX);
                        w_dir_y_nxt  = 1'b0;
                    end else begin
                        w_ball_y_nxt = 10'(w_by + C_BSPD);
                    end
                end else begin
                    if (w_by <= C_TOP + C_BSPD) begin
                        w_ball_y_nxt = 10'(C_TOP);
                        w_dir_y_nxt  = 1'b1;
                    end else begin
                        w_ball_y_nxt = 10'(w_by - C_BSPD);
                    end
                end
                // On a miss x stays put; POINT recentres the ball next cycle.
                if (w_hit_l) begin
                    w_ball_x_nxt = 10'(C_P1_FACE);
                    w_dir_x_nxt  = 1'b1;
                end else if (w_hit_r) begin
                    w_ball_x_nxt = 10'(C_P2_FACE);
                    w_dir_x_nxt  = 1'b0;
                end else if (w_miss_l) begin
                    w_point_p2_nxt = 1'b1;
                end else if (w_miss_r) begin
                    w_point_p2_nxt = 1'b0;
                end else begin
                    w_ball_x_nxt = r_dir_x ? 10'(w_bx + C_BSPD) : 10'(w_bx - C_BSPD);
                end
            end
            S_POINT: begin
                if (r_point_p2) w_p2_score_nxt = w_score_inc;
                else            w_p1_score_nxt = w_score_inc;
                if (!w_win) begin
                    w_ball_x_nxt = C_CX;
                    w_ball_y_nxt = C_CY;
                    w_dir_x_nxt  = !r_point_p2;
                    w_cnt_nxt    = '0;
                end
            end
            S_GAME_OVER: if (serve) begin
                w_p1_score_nxt = 4'd0;
                w_p2_score_nxt = 4'd0;
                w_ball_x_nxt   = C_CX;
                w_ball_y_nxt   = C_CY;
                w_cnt_nxt      = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_ball_x   <= C_CX;
            r_ball_y   <= C_CY;
            r_dir_x    <= 1'b1;
            r_dir_y    <= 1'b1;
            r_p1_y     <= C_PAD0;
            r_p2_y     <= C_PAD0;
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_cnt      <= '0;
            r_point_p2 <= 1'b0;
        end else begin
            r_ball_x   <= w_ball_x_nxt;
            r_ball_y   <= w_ball_y_nxt;
            r_dir_x    <= w_dir_x_nxt;
            r_dir_y    <= w_dir_y_nxt;
            r_p1_y     <= w_p1_y_nxt;
            r_p2_y     <= w_p2_y_nxt;
            r_p1_score <= w_p1_score_nxt;
            r_p2_score <= w_p2_score_nxt;
            r_cnt      <= w_cnt_nxt;
            r_point_p2 <= w_point_p2_nxt;
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign P1_paddle_y = r_p1_y;
    assign P2_paddle_y = r_p2_y;
    assign P1_score    = r_p1_score;
    assign P2_score    = r_p2_score;
    assign state       = r_state;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl
// Reference model tracks the game with plain integers and signed velocities.
module tb_pong_game_ctrl;

    localparam int ST_IDLE = 0, ST_SW = 1, ST_PLAY = 2, ST_POINT = 3, ST_GO = 4;
    localparam int BS = 5, PW = 10, PH = 120, P1X = 20, P2X = 610;
    localparam int BSPD = 2, PSPD = 4, WIN = 9, DELAY = 60;

    logic       CLK_50 = 1'b0;
    logic       RST_N = 1'b0;
    logic       frame_tick = 1'b0, serve = 1'b0;
    logic       P1_up = 1'b0, P1_down = 1'b0, P2_up = 1'b0, P2_down = 1'b0;
    logic [9:0] ball_x, ball_y, P1_paddle_y, P2_paddle_y;
    logic [3:0] P1_score, P2_score;
    logic [2:0] state;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    int m_state, m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_cnt, m_scorer;

    pong_game_ctrl dut (
        .CLK_50(CLK_50), .RST_N(RST_N), .frame_tick(frame_tick), .serve(serve),
        .P1_up(P1_up), .P1_down(P1_down), .P2_up(P2_up), .P2_down(P2_down),
        .ball_x(ball_x), .ball_y(ball_y), .P1_paddle_y(P1_paddle_y), .P2_paddle_y(P2_paddle_y),
        .P1_score(P1_score), .P2_score(P2_score), .state(state), .game_over(game_over)
    );

    always #5 CLK_50 = ~CLK_50;

    function automatic int pad_move(int p, bit up, bit dn);
        int n;
        n = p;
        if (up && !dn) n = p - PSPD;
        if (dn && !up) n = p + PSPD;
        if (n < 2) n = 2;
        if (n > 478 - PH) n = 478 - PH;
        return n;
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_bx = 320; m_by = 240; m_vx = 1; m_vy = 1;
        m_p1 = 180; m_p2 = 180; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_scorer = 0;
    endtask

    task automatic model_update(input bit tick, input bit srv, input bit [3:0] btn);
        int  op1, op2, oby, face1, face2;
        bit  ov1, ov2, won;
        op1 = m_p1; op2 = m_p2; oby = m_by;
        face1 = P1X + PW; face2 = P2X - BS;
        case (m_state)
            ST_IDLE: if (srv) begin m_state = ST_SW; m_cnt = 0; end
            ST_SW: if (tick) begin
                m_p1 = pad_move(op1, btn[3], btn[2]);
                m_p2 = pad_move(op2, btn[1], btn[0]);
                m_cnt++;
                if (m_cnt == DELAY) begin m_state = ST_PLAY; m_cnt = 0; end
            end
            ST_PLAY: if (tick) begin
                m_p1 = pad_move(op1, btn[3], btn[2]);
                m_p2 = pad_move(op2, btn[1], btn[0]);
                ov1 = (oby + BS > op1) && (oby < op1 + PH);
                ov2 = (oby + BS > op2) && (oby < op2 + PH);
                m_by = oby + m_vy * BSPD;
                if (m_vy > 0 && m_by >= 478 - BS) begin m_by = 478 - BS; m_vy = -1; end
                else if (m_vy < 0 && m_by <= 2) begin m_by = 2; m_vy = 1; end
                if (m_vx < 0) begin
                    if (m_bx >= face1 && m_bx - BSPD <= face1 && ov1) begin m_bx = face1; m_vx = 1; end
                    else if (m_bx - BSPD <= 2) begin m_state = ST_POINT; m_scorer = 2; end
                    else m_bx = m_bx - BSPD;
                end else begin
                    if (m_bx <= face2 && m_bx + BSPD >= face2 && ov2) begin m_bx = face2; m_vx = -1; end
                    else if (m_bx + BS + BSPD >= 637) begin m_state = ST_POINT; m_scorer = 1; end
                    else m_bx = m_bx + BSPD;
                end
            end
            ST_POINT: begin
                if (m_scorer == 1) begin m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; won = (m_s1 == WIN); end
                else begin m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; won = (m_s2 == WIN); end
                if (won) m_state = ST_GO;
                else begin
                    m_bx = 320; m_by = 240; m_vx = (m_scorer == 2) ? -1 : 1;
                    m_cnt = 0; m_state = ST_SW;
                end
            end
            ST_GO: if (srv) begin
                m_s1 = 0; m_s2 = 0; m_bx = 320; m_by = 240; m_cnt = 0; m_state = ST_SW;
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit tick, input bit srv, input bit [3:0] btn);
        frame_tick = tick; serve = srv;
        {P1_up, P1_down, P2_up, P2_down} = btn;
        @(posedge CLK_50);
        model_update(tick, srv, btn);
        #1;
        frame_tick = 1'b0; serve = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK_50);
        #1 RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ball_x, ball_y, P1_paddle_y, P2_paddle_y} !== {10'd320, 10'd240, 10'd180, 10'd180}) begin
            errors++;
            $display("FAIL reset_pos got %0d %0d %0d %0d exp 320 240 180 180", ball_x, ball_y, P1_paddle_y, P2_paddle_y);
        end
        checks++;
        if ({P1_score, P2_score, state, game_over} !== {4'd0, 4'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctl got s1=%0d s2=%0d st=%0d go=%0d exp 0 0 0 0", P1_score, P2_score, state, game_over);
        end
        step(1, 0, 4'b0000);
        checks++;
        if (state !== 3'(ST_IDLE) || ball_x !== 10'd320) begin
            errors++;
            $display("FAIL idle_tick_ignored got st=%0d bx=%0d exp st=0 bx=320", state, ball_x);
        end
    endtask

    task automatic test_serve_delay();
        step(0, 1, 4'b0000);
        checks++;
        if (state !== 3'(ST_SW)) begin errors++; $display("FAIL serve_to_wait got %0d exp %0d", state, ST_SW); end
        for (int k = 1; k <= DELAY; k++) begin
            step(1, 0, 4'b0000);
            checks++;
            if (state !== ((k == DELAY) ? 3'(ST_PLAY) : 3'(ST_SW))) begin
                errors++;
                $display("FAIL serve_delay tick=%0d got %0d exp %0d", k, state, (k == DELAY) ? ST_PLAY : ST_SW);
            end
            step(0, 0, 4'b0000);
        end
        step(1, 0, 4'b0000);
        checks++;
        if (ball_x !== 10'd322 || ball_y !== 10'd242) begin
            errors++;
            $display("FAIL first_play_step got (%0d,%0d) exp (322,242)", ball_x, ball_y);
        end
    endtask

    task automatic test_paddles();
        do_reset();
        step(0, 1, 4'b0000);
        for (int k = 0; k < 46; k++) begin
            step(1, 0, 4'b1001);
            checks++;
            if (P1_paddle_y !== 10'(m_p1) || P2_paddle_y !== 10'(m_p2)) begin
                errors++;
                $display("FAIL paddle_move tick=%0d got %0d %0d exp %0d %0d", k, P1_paddle_y, P2_paddle_y, m_p1, m_p2);
            end
            step(0, 0, 4'b1001);
        end
        checks++;
        if (P1_paddle_y !== 10'd2 || P2_paddle_y !== 10'd358) begin
            errors++;
            $display("FAIL paddle_clamp got %0d %0d exp 2 358", P1_paddle_y, P2_paddle_y);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 4'b1111);
            step(0, 0, 4'b1111);
        end
        checks++;
        if (P1_paddle_y !== 10'd2 || P2_paddle_y !== 10'd358) begin
            errors++;
            $display("FAIL paddle_both_held got %0d %0d exp 2 358", P1_paddle_y, P2_paddle_y);
        end
    endtask

    function automatic bit [1:0] track(int p, int by);
        int pc, bc;
        pc = p + PH / 2; bc = by + BS / 2;
        if (bc < pc - 8) return 2'b10;
        if (bc > pc + 8) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit [1:0] avoid(int p, int by);
        return (by + BS / 2 < p + PH / 2) ? 2'b01 : 2'b10;
    endfunction

    task automatic test_random_play();
        logic [51:0] got, exp;
        bit [1:0]    b1, b2;
        bit          srv;
        int          cyc;
        cyc = 0;
        while (m_state != ST_GO && cyc < 60000) begin
            if (m_s2 < 3) begin b1 = avoid(m_p1, m_by); b2 = track(m_p2, m_by); end
            else          begin b1 = track(m_p1, m_by); b2 = avoid(m_p2, m_by); end
            if ($urandom_range(7) == 0) b1 = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) b2 = 2'($urandom_range(3));
            srv = ($urandom_range(15) == 0);
            step(cyc % 2 == 0, srv, {b1, b2});
            got = {ball_x, ball_y, P1_paddle_y, P2_paddle_y, P1_score, P2_score, state, game_over};
            exp = {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2), 3'(m_state), 1'(m_state == ST_GO)};
            checks++;
            if (got !== exp) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL rnd_play cyc=%0d got bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d st=%0d go=%0d exp bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d st=%0d",
                             cyc, ball_x, ball_y, P1_paddle_y, P2_paddle_y, P1_score, P2_score, state, game_over,
                             m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_state);
            end
            cyc++;
        end
        checks++;
        if (m_state != ST_GO) begin errors++; $display("FAIL rnd_timeout cycles=%0d model_state=%0d exp %0d", cyc, m_state, ST_GO); end
        checks++;
        if (P1_score !== 4'd9 || game_over !== 1'b1 || state !== 3'(ST_GO)) begin
            errors++;
            $display("FAIL game_over got s1=%0d go=%0d st=%0d exp 9 1 %0d", P1_score, game_over, state, ST_GO);
        end
        checks++;
        if (P2_score < 4'd3) begin errors++; $display("FAIL p2_scored got %0d exp >=3", P2_score); end
    endtask

    task automatic test_game_over_restart();
        step(1, 0, 4'b0000);
        checks++;
        if (state !== 3'(ST_GO) || ball_x !== 10'(m_bx) || ball_y !== 10'(m_by)) begin
            errors++;
            $display("FAIL go_frozen got st=%0d (%0d,%0d) exp st=%0d (%0d,%0d)", state, ball_x, ball_y, ST_GO, m_bx, m_by);
        end
        step(1, 1, 4'b0000);
        checks++;
        if ({state, P1_score, P2_score, ball_x, ball_y, game_over} !== {3'(ST_SW), 4'd0, 4'd0, 10'd320, 10'd240, 1'b0}) begin
            errors++;
            $display("FAIL go_restart got st=%0d s=%0d/%0d (%0d,%0d) go=%0d exp 1 0/0 (320,240) 0",
                     state, P1_score, P2_score, ball_x, ball_y, game_over);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < DELAY + 5; k++) begin
            step(1, 0, 4'b0000);
            step(0, 0, 4'b0000);
        end
        checks++;
        if (state !== 3'(ST_PLAY) || ball_x !== 10'(m_bx)) begin
            errors++;
            $display("FAIL pre_reset_play got st=%0d bx=%0d exp %0d %0d", state, ball_x, ST_PLAY, m_bx);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({ball_x, ball_y, P1_paddle_y, P2_paddle_y, P1_score, P2_score, state, game_over} !==
            {10'd320, 10'd240, 10'd180, 10'd180, 4'd0, 4'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got (%0d,%0d) p=%0d/%0d s=%0d/%0d st=%0d go=%0d exp (320,240) 180/180 0/0 0 0",
                     ball_x, ball_y, P1_paddle_y, P2_paddle_y, P1_score, P2_score, state, game_over);
        end
        model_reset();
        @(negedge CLK_50);
        RST_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 4'b1010);
            step(0, 0, 4'b1010);
        end
        checks++;
        if (state !== 3'(ST_IDLE) || ball_x !== 10'd320 || P1_paddle_y !== 10'd180) begin
            errors++;
            $display("FAIL post_reset_idle got st=%0d bx=%0d p1=%0d exp 0 320 180", state, ball_x, P1_paddle_y);
        end
        step(0, 1, 4'b0000);
        checks++;
        if (state !== 3'(ST_SW)) begin errors++; $display("FAIL post_reset_serve got %0d exp %0d", state, ST_SW); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve_delay();
        test_paddles();
        do_reset();
        test_random_play();
        test_game_over_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
